alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_mc.sv | 111 +++++++++++
 tb/tb_alu_mc.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, opcode width and FSM state encoding for the multi-cycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd9;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd10;
  localparam logic [OP_W-1:0] OP_MULU = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for all single-cycle opcodes plus undefined-op detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing FSM decides when the result is captured.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OP_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             bad_op
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   sh;

  // Decode the opcode into a result and flags; undefined codes give zero with bad_op set.
  always_comb begin
    sum    = a + b;
    diff   = a - b;
    sh     = b[SHW-1:0];
    result = '0;
    ovf    = 1'b0;
    bad_op = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLL:  result = a << sh;
      OP_SRL:  result = a >> sh;
      OP_SRA:  result = $signed(a) >>> sh;
      OP_SLT:  result[0] = $signed(a) < $signed(b);
      OP_SLTU: result[0] = a < b;
      // The multiply is produced by the shift-add iterator in the parent, not here.
      OP_MULU: result = '0;
      default: bad_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready wrapper around alu_core plus a shift-add unsigned multiplier.
// Latency: 1 cycle for ops 0-10 and undefined ops, WIDTH+1 cycles for MULU.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY or DONE without out_ready.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             ovf,
  output logic             bad_op
);

  if (WIDTH < 4) begin : g_width_check
    $error("alu_mc: WIDTH must be at least 4");
  end

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             core_bad_op;
  logic             accept;

  alu_core #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_core (
    .a     (a),
    .b     (b),
    .op    (op),
    .result(core_result),
    .ovf   (core_ovf),
    .bad_op(core_bad_op)
  );

  // A new op can enter when idle, or when the held result leaves on this same edge.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  // Masked during reset so a stale DONE is never presented while reset is held.
  assign out_valid = (state == DONE) && !reset;
  assign accept    = in_valid && in_ready;

  // Single FSM process: handshakes, single-cycle capture and the MULU shift-add iterator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      c       <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      bad_op  <= 1'b0;
      counter <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (op == OP_MULU) begin
              mcand   <= a;
              mplier  <= b;
              acc     <= '0;
              counter <= CNT_LOAD;
              state   <= BUSY;
            end else begin
              c      <= core_result;
              zero   <= (core_result == '0);
              ovf    <= core_ovf;
              bad_op <= core_bad_op;
              state  <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (counter == '0) begin
            // All WIDTH steps are done; the low WIDTH bits of the product sit in acc.
            c      <= acc;
            zero   <= (acc == '0);
            ovf    <= 1'b0;
            bad_op <= 1'b0;
            state  <= DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            counter <= counter - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.
// Latency: checks 1-cycle ops and WIDTH+1-edge MULU completion.
// Backpressure: exercises result hold, back-to-back accept and reset abort.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk;
  logic reset;

  logic        in_valid, in_ready, out_valid, out_ready, zero, ovf, bad_op;
  logic [31:0] a, b, c;
  logic [3:0]  op;

  logic       w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_zero, w8_ovf, w8_bad_op;
  logic [7:0] w8_a, w8_b, w8_c;
  logic [3:0] w8_op;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp32 [0:10] = '{32'd6, 32'd4, 32'd1, 32'd5, 32'd4, 32'hFFFF_FFFA,
                                32'd10, 32'd2, 32'd2, 32'd0, 32'd0};
  logic [7:0]  exp8  [0:10] = '{8'd6, 8'd4, 8'd1, 8'd5, 8'd4, 8'hFA,
                                8'd10, 8'd2, 8'd2, 8'd0, 8'd0};

  alu_mc #(.WIDTH(32), .OPW(4)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .zero(zero), .ovf(ovf), .bad_op(bad_op)
  );

  alu_mc #(.WIDTH(8), .OPW(4)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .a(w8_a), .b(w8_b), .op(w8_op), .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .c(w8_c), .zero(w8_zero), .ovf(w8_ovf), .bad_op(w8_bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for exactly one edge (block must be ready), then drop in_valid.
  task automatic issue32(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop);
    w8_a = ia; w8_b = ib; w8_op = iop; w8_in_valid = 1'b1;
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
  endtask

  // Count edges until out_valid, noting whether in_ready ever rose while busy.
  task automatic wait_out32(input int limit, output int edges, output bit busy_ok);
    busy_ok = (in_ready === 1'b0);
    edges = limit;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        edges = k;
        break;
      end
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
  endtask

  task automatic wait_out8(input int limit, output int edges, output bit busy_ok);
    busy_ok = (w8_in_ready === 1'b0);
    edges = limit;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (w8_out_valid === 1'b1) begin
        edges = k;
        break;
      end
      if (w8_in_ready !== 1'b0) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    w8_in_valid = 1'b0; w8_out_ready = 1'b0; w8_a = '0; w8_b = '0; w8_op = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset32_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    tests++;
    if ({c, zero, ovf, bad_op} !== 35'd0) begin
      fails++; $display("FAIL reset32_out: c=%h z=%b o=%b bad=%b want all 0", c, zero, ovf, bad_op);
    end
    tests++;
    if (w8_out_valid !== 1'b0 || w8_in_ready !== 1'b1 || {w8_c, w8_zero, w8_ovf, w8_bad_op} !== 11'd0) begin
      fails++; $display("FAIL reset8: vld=%b rdy=%b c=%h z=%b o=%b bad=%b want 0 1 0 0 0 0",
                        w8_out_valid, w8_in_ready, w8_c, w8_zero, w8_ovf, w8_bad_op);
    end
    reset = 1'b0;
  endtask

  task automatic test_ops_w32();
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue32(32'd5, 32'd1, 4'(i));
      tests++;
      if (out_valid !== 1'b1 || c !== exp32[i] || zero !== (exp32[i] == 32'd0) ||
          ovf !== 1'b0 || bad_op !== 1'b0) begin
        fails++; $display("FAIL ops32 op=%0d: vld=%b c=%h z=%b o=%b bad=%b want 1 %h", i,
                          out_valid, c, zero, ovf, bad_op, exp32[i]);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL consume32: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_arith_w32();
    out_ready = 1'b1;
    issue32(32'h7FFF_FFFF, 32'd1, OP_ADD);
    tests++;
    if (c !== 32'h8000_0000 || ovf !== 1'b1 || zero !== 1'b0) begin
      fails++; $display("FAIL add_ovf32: c=%h o=%b z=%b want 80000000 1 0", c, ovf, zero);
    end
    @(posedge clk); #1;
    issue32(32'd0, 32'd0, OP_SUB);
    tests++;
    if (c !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0) begin
      fails++; $display("FAIL sub_zero32: c=%h z=%b o=%b want 0 1 0", c, zero, ovf);
    end
    @(posedge clk); #1;
    issue32(32'h8000_0000, 32'd1, OP_SUB);
    tests++;
    if (c !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
      fails++; $display("FAIL sub_ovf32: c=%h o=%b want 7fffffff 1", c, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mulu_w32();
    int edges;
    bit busy_ok;
    out_ready = 1'b1;
    issue32(32'd7, 32'd6, OP_MULU);
    // Offer a competing ADD throughout BUSY; it must not be taken.
    a = 32'd1; b = 32'd1; op = OP_ADD; in_valid = 1'b1;
    wait_out32(40, edges, busy_ok);
    in_valid = 1'b0;
    tests++;
    if (edges != 33) begin
      fails++; $display("FAIL mulu32_latency: edges=%0d want 33", edges);
    end
    tests++;
    if (!busy_ok) begin
      fails++; $display("FAIL mulu32_busy_ready: in_ready rose in BUSY, want 0");
    end
    tests++;
    if (c !== 32'd42 || ovf !== 1'b0 || bad_op !== 1'b0 || zero !== 1'b0) begin
      fails++; $display("FAIL mulu32_7x6: c=%h o=%b bad=%b z=%b want 2a 0 0 0", c, ovf, bad_op, zero);
    end
    @(posedge clk); #1;
    issue32(32'hFFFF_FFFF, 32'd2, OP_MULU);
    wait_out32(40, edges, busy_ok);
    tests++;
    if (out_valid !== 1'b1 || c !== 32'hFFFF_FFFE || ovf !== 1'b0) begin
      fails++; $display("FAIL mulu32_trunc: vld=%b c=%h o=%b want 1 fffffffe 0", out_valid, c, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold_back_to_back();
    out_ready = 1'b0;
    issue32(32'd9, 32'd3, OP_ADD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || c !== 32'd12 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold32 cyc=%0d: vld=%b c=%h rdy=%b want 1 c 0", i, out_valid, c, in_ready);
      end
    end
    out_ready = 1'b1;
    a = 32'd1; b = 32'd1; op = OP_ADD; in_valid = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || c !== 32'd2) begin
      fails++; $display("FAIL b2b_result: vld=%b c=%h want 1 2", out_valid, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_op_w32();
    out_ready = 1'b1;
    issue32(32'd5, 32'd1, 4'd13);
    tests++;
    if (out_valid !== 1'b1 || bad_op !== 1'b1 || c !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0) begin
      fails++; $display("FAIL badop32: vld=%b bad=%b c=%h z=%b o=%b want 1 1 0 1 0",
                        out_valid, bad_op, c, zero, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    bit seen;
    out_ready = 1'b1;
    issue32(32'd7, 32'd6, OP_MULU);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || c !== 32'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_busy: vld=%b c=%h rdy=%b want 0 0 1", out_valid, c, in_ready);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL rst_abort: aborted MULU result presented, want none");
    end
    issue32(32'd2, 32'd3, OP_ADD);
    tests++;
    if (out_valid !== 1'b1 || c !== 32'd5) begin
      fails++; $display("FAIL rst_after_add: vld=%b c=%h want 1 5", out_valid, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ops_w8();
    w8_out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue8(8'd5, 8'd1, 4'(i));
      tests++;
      if (w8_out_valid !== 1'b1 || w8_c !== exp8[i] || w8_ovf !== 1'b0 || w8_bad_op !== 1'b0) begin
        fails++; $display("FAIL ops8 op=%0d: vld=%b c=%h o=%b bad=%b want 1 %h", i,
                          w8_out_valid, w8_c, w8_ovf, w8_bad_op, exp8[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arith_w8();
    w8_out_ready = 1'b1;
    issue8(8'h7F, 8'd1, OP_ADD);
    tests++;
    if (w8_c !== 8'h80 || w8_ovf !== 1'b1) begin
      fails++; $display("FAIL add_ovf8: c=%h o=%b want 80 1", w8_c, w8_ovf);
    end
    @(posedge clk); #1;
    issue8(8'h80, 8'h0A, OP_SRA);
    tests++;
    if (w8_c !== 8'hE0) begin
      fails++; $display("FAIL sra8_mask: c=%h want e0", w8_c);
    end
    @(posedge clk); #1;
    issue8(8'h01, 8'h09, OP_SLL);
    tests++;
    if (w8_c !== 8'h02) begin
      fails++; $display("FAIL sll8_mask: c=%h want 02", w8_c);
    end
    @(posedge clk); #1;
    issue8(8'd5, 8'd1, 4'd13);
    tests++;
    if (w8_bad_op !== 1'b1 || w8_c !== 8'd0 || w8_zero !== 1'b1) begin
      fails++; $display("FAIL badop8: bad=%b c=%h z=%b want 1 0 1", w8_bad_op, w8_c, w8_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mulu_w8();
    int edges;
    bit busy_ok;
    w8_out_ready = 1'b1;
    issue8(8'd7, 8'd6, OP_MULU);
    wait_out8(20, edges, busy_ok);
    tests++;
    if (edges != 9) begin
      fails++; $display("FAIL mulu8_latency: edges=%0d want 9", edges);
    end
    tests++;
    if (!busy_ok || w8_c !== 8'd42) begin
      fails++; $display("FAIL mulu8_7x6: busy_ok=%b c=%h want 1 2a", busy_ok, w8_c);
    end
    @(posedge clk); #1;
    issue8(8'hFF, 8'd2, OP_MULU);
    wait_out8(20, edges, busy_ok);
    tests++;
    if (w8_out_valid !== 1'b1 || w8_c !== 8'hFE || w8_ovf !== 1'b0) begin
      fails++; $display("FAIL mulu8_trunc: vld=%b c=%h o=%b want 1 fe 0", w8_out_valid, w8_c, w8_ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ops_w32();
    test_arith_w32();
    test_mulu_w32();
    test_hold_back_to_back();
    test_bad_op_w32();
    test_reset_busy();
    test_ops_w8();
    test_arith_w8();
    test_mulu_w8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
